// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// master = datapath (drives events, consumes enables/flushes); slave = controller.
interface pipeline_hazard_controller_if #(
    parameter int REG_W = 5
);
    // events observed in the pipeline
    logic             ihit;
    logic             dhit;
    logic             mem_dreq;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_regdest;
    logic             mem_redirect;
    logic             mem_halt;

    // PC / pipeline-latch control
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;

    modport master (
        output ihit, dhit, mem_dreq,
        output id_rs, id_rt, ex_memread, ex_regdest,
        output mem_redirect, mem_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush
    );

    modport slave (
        input  ihit, dhit, mem_dreq,
        input  id_rs, id_rt, ex_memread, ex_regdest,
        input  mem_redirect, mem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, load-use, redirect, halt.
// Ports: clk, rst (async, active-high); hz (slave bundle: events in, enables/flushes out);
//        halted, state_o (RUN=0 LDUSE=1 DWAIT=2 REDIR=3 HALT=4), stall_cycles, redirect_cnt.
// Optional perf counters enabled by defining HAZ_PERF_EN; otherwise the counter ports read 0.
module pipeline_hazard_controller #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    pipeline_hazard_controller_if.slave hz,
    output logic                       halted,
    output logic [2:0]                 state_o,
    output logic [CNT_W-1:0]           stall_cycles,
    output logic [CNT_W-1:0]           redirect_cnt
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        LDUSE = 3'd1,
        DWAIT = 3'd2,
        REDIR = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // enable vector order: {pc, ifid, idex, exmem, memwb}
    localparam int PC = 4;
    localparam int IFID = 3;
    // flush vector order: {ifid, idex, exmem}
    localparam int FL_IFID = 2;
    localparam int FL_IDEX = 1;

    state_t     state;
    state_t     nxt;
    logic [4:0] en;
    logic [2:0] fl;

    logic dwait_ev;
    logic lu_hit;
    logic lu_ok;
    logic ev_halt;
    logic ev_dw;
    logic ev_rd;
    logic ev_lu;
    logic ev_im;

    assign dwait_ev = hz.mem_dreq & ~hz.dhit;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign lu_hit = hz.ex_memread
                  & (hz.ex_regdest != ZERO_REG)
                  & ((hz.ex_regdest == hz.id_rs) | (hz.ex_regdest == hz.id_rt));

    // the cycle after a load-use bubble the same pair is still visible; ignore it
    assign lu_ok = (state == RUN) & lu_hit;

    // priority-resolved, mutually exclusive events for RUN/LDUSE
    assign ev_halt = hz.mem_halt;
    assign ev_dw   = ~ev_halt & dwait_ev;
    assign ev_rd   = ~ev_halt & ~dwait_ev & hz.mem_redirect;
    assign ev_lu   = ~ev_halt & ~dwait_ev & ~hz.mem_redirect & lu_ok;
    assign ev_im   = ~ev_halt & ~dwait_ev & ~hz.mem_redirect & ~lu_ok & ~hz.ihit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        en  = 5'b11111;
        fl  = 3'b000;
        nxt = state;
        unique case (state)
            RUN, LDUSE: begin
                nxt = RUN;
                unique case (1'b1)
                    ev_halt: begin
                        en  = 5'b00000;
                        nxt = HALT;
                    end
                    ev_dw: begin
                        en  = 5'b00000;
                        nxt = DWAIT;
                    end
                    ev_rd: begin
                        // PC loads the target, younger stages are squashed
                        fl  = 3'b111;
                        nxt = REDIR;
                    end
                    ev_lu: begin
                        en[PC]      = 1'b0;
                        en[IFID]    = 1'b0;
                        fl[FL_IDEX] = 1'b1;
                        nxt         = LDUSE;
                    end
                    ev_im: begin
                        en[PC]      = 1'b0;
                        fl[FL_IFID] = 1'b1;
                    end
                    default: ;
                endcase
            end
            DWAIT: begin
                // redirect/halt stay parked in EX/MEM until the access completes
                if (hz.dhit) begin
                    nxt = RUN;
                end else begin
                    en = 5'b00000;
                end
            end
            REDIR: begin
                if (dwait_ev) begin
                    en  = 5'b00000;
                    nxt = DWAIT;
                end else begin
                    en[PC]      = hz.ihit;
                    fl[FL_IFID] = ~hz.ihit;
                    if (hz.ihit) begin
                        nxt = RUN;
                    end
                end
            end
            HALT: begin
                en  = 5'b00000;
                nxt = HALT;
            end
            default: begin
                nxt = RUN;
            end
        endcase
    end

    // while reset is held the pipeline sees the idle pattern regardless of inputs
    assign hz.pc_en       = rst | en[4];
    assign hz.ifid_en     = rst | en[3];
    assign hz.idex_en     = rst | en[2];
    assign hz.exmem_en    = rst | en[1];
    assign hz.memwb_en    = rst | en[0];
    assign hz.ifid_flush  = ~rst & fl[2];
    assign hz.idex_flush  = ~rst & fl[1];
    assign hz.exmem_flush = ~rst & fl[0];

    assign halted  = (state == HALT);
    assign state_o = state;

`ifdef HAZ_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] redir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            if (!en[PC] && state != HALT && stall_q != CNT_MAX) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (state == RUN && nxt == REDIR && redir_q != CNT_MAX) begin
                redir_q <= redir_q + CNT_ONE;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign redirect_cnt = redir_q;
`else
    assign stall_cycles = '0;
    assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with an expected-output queue.
// Counter expectations follow HAZ_PERF_EN the same way the design does.
module tb_pipeline_hazard_controller;

    localparam logic [2:0] S_RUN = 3'd0;
    localparam logic [2:0] S_LDU = 3'd1;
    localparam logic [2:0] S_DW  = 3'd2;
    localparam logic [2:0] S_RD  = 3'd3;
    localparam logic [2:0] S_HLT = 3'd4;
    localparam logic [4:0] ALL   = 5'b11111;
    localparam logic [4:0] NONE  = 5'b00000;

`ifdef HAZ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic [4:0] en;
        logic [2:0] fl;
        logic       hlt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        halted;
    logic [2:0]  state_o;
    logic [31:0] stall_cycles;
    logic [31:0] redirect_cnt;

    int          checks = 0;
    int          errors = 0;
    int unsigned stall_m = 0;
    int unsigned redir_m = 0;
    exp_t        q[$];

    pipeline_hazard_controller_if #(.REG_W(5)) hz ();

    pipeline_hazard_controller #(
        .REG_W(5),
        .CNT_W(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hz           (hz),
        .halted       (halted),
        .state_o      (state_o),
        .stall_cycles (stall_cycles),
        .redirect_cnt (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] s, input logic [4:0] e,
                                input logic [2:0] f, input logic h);
        exp_t r;
        r.st  = s;
        r.en  = e;
        r.fl  = f;
        r.hlt = h;
        return r;
    endfunction

    task automatic drv(input logic ih, input logic dh, input logic dq,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] rd,
                       input logic rdr, input logic hl);
        @(negedge clk);
        hz.ihit         = ih;
        hz.dhit         = dh;
        hz.mem_dreq     = dq;
        hz.id_rs        = rs;
        hz.id_rt        = rt;
        hz.ex_memread   = mr;
        hz.ex_regdest   = rd;
        hz.mem_redirect = rdr;
        hz.mem_halt     = hl;
    endtask

    task automatic idle();
        drv(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
    endtask

    // expectation is queued as soon as stimulus settles, compared once outputs settle
    task automatic exp_chk(input string tag, input exp_t e);
        exp_t want;
        exp_t obs;
        q.push_back(e);
        if (!e.en[4] && e.st != S_HLT) stall_m++;
        #2;
        want = q.pop_front();
        obs  = {state_o,
                hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                hz.ifid_flush, hz.idex_flush, hz.exmem_flush,
                halted};
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic cnt_chk(input string tag);
        logic [31:0] es;
        logic [31:0] er;
        es = PERF ? stall_m : 32'd0;
        er = PERF ? redir_m : 32'd0;
        checks++;
        assert (stall_cycles === es) else begin
            errors++;
            $error("FAIL %s_stall: observed %0d expected %0d", tag, stall_cycles, es);
        end
        checks++;
        assert (redirect_cnt === er) else begin
            errors++;
            $error("FAIL %s_redir: observed %0d expected %0d", tag, redirect_cnt, er);
        end
    endtask

    initial begin
        rst             = 1'b1;
        hz.ihit         = 1'b1;
        hz.dhit         = 1'b0;
        hz.mem_dreq     = 1'b0;
        hz.id_rs        = 5'd1;
        hz.id_rt        = 5'd2;
        hz.ex_memread   = 1'b0;
        hz.ex_regdest   = 5'd3;
        hz.mem_redirect = 1'b0;
        hz.mem_halt     = 1'b0;
        #1;
        exp_chk("reset", mk(S_RUN, ALL, 3'b000, 1'b0));
        cnt_chk("cnt_reset");
        @(negedge clk);
        rst = 1'b0;

        idle();
        exp_chk("idle", mk(S_RUN, ALL, 3'b000, 1'b0));

        // load-use on rs
        drv(1'b1, 1'b0, 1'b0, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0);
        exp_chk("lu_rs_stall", mk(S_RUN, 5'b00111, 3'b010, 1'b0));
        drv(1'b1, 1'b0, 1'b0, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0);
        exp_chk("lu_rs_state", mk(S_LDU, ALL, 3'b000, 1'b0));
        idle();
        exp_chk("lu_rs_done", mk(S_RUN, ALL, 3'b000, 1'b0));

        // load-use on rt
        drv(1'b1, 1'b0, 1'b0, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        exp_chk("lu_rt_stall", mk(S_RUN, 5'b00111, 3'b010, 1'b0));
        idle();
        exp_chk("lu_rt_state", mk(S_LDU, ALL, 3'b000, 1'b0));

        // r0 destination never stalls
        drv(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        exp_chk("rd_zero", mk(S_RUN, ALL, 3'b000, 1'b0));
        drv(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        exp_chk("rd_zero2", mk(S_RUN, ALL, 3'b000, 1'b0));

        // instruction miss
        drv(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
        exp_chk("imiss", mk(S_RUN, 5'b01111, 3'b100, 1'b0));
        idle();
        exp_chk("imiss_rec", mk(S_RUN, ALL, 3'b000, 1'b0));
        cnt_chk("cnt_a");

        // data wait for 3 cycles
        drv(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
        exp_chk("dw1", mk(S_RUN, NONE, 3'b000, 1'b0));
        drv(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
        exp_chk("dw2", mk(S_DW, NONE, 3'b000, 1'b0));
        drv(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
        exp_chk("dw3", mk(S_DW, NONE, 3'b000, 1'b0));
        drv(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
        exp_chk("dw_hit", mk(S_DW, ALL, 3'b000, 1'b0));
        idle();
        exp_chk("dw_done", mk(S_RUN, ALL, 3'b000, 1'b0));
        cnt_chk("cnt_dw");

        // redirect with 2-cycle target miss; load-use masked in REDIR
        drv(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
        exp_chk("rd_take", mk(S_RUN, ALL, 3'b111, 1'b0));
        redir_m++;
        drv(1'b0, 1'b0, 1'b0, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0);
        exp_chk("rd_miss1", mk(S_RD, 5'b01111, 3'b100, 1'b0));
        drv(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
        exp_chk("rd_miss2", mk(S_RD, 5'b01111, 3'b100, 1'b0));
        idle();
        exp_chk("rd_hit", mk(S_RD, ALL, 3'b000, 1'b0));
        idle();
        exp_chk("rd_done", mk(S_RUN, ALL, 3'b000, 1'b0));
        cnt_chk("cnt_rd");

        // data stall beats a simultaneous redirect; redirect taken after dhit
        drv(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
        exp_chk("pri_stall", mk(S_RUN, NONE, 3'b000, 1'b0));
        drv(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
        exp_chk("pri_wait", mk(S_DW, NONE, 3'b000, 1'b0));
        drv(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
        exp_chk("pri_hit", mk(S_DW, ALL, 3'b000, 1'b0));
        drv(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
        exp_chk("pri_redir", mk(S_RUN, ALL, 3'b111, 1'b0));
        redir_m++;
        idle();
        exp_chk("pri_fetch", mk(S_RD, ALL, 3'b000, 1'b0));
        idle();
        exp_chk("pri_done", mk(S_RUN, ALL, 3'b000, 1'b0));
        cnt_chk("cnt_pri");

        // asynchronous reset in the middle of a data wait
        drv(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
        exp_chk("ar_stall", mk(S_RUN, NONE, 3'b000, 1'b0));
        drv(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
        exp_chk("ar_wait", mk(S_DW, NONE, 3'b000, 1'b0));
        rst     = 1'b1;
        stall_m = 0;
        redir_m = 0;
        exp_chk("async_rst", mk(S_RUN, ALL, 3'b000, 1'b0));
        hz.mem_dreq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cnt_chk("cnt_rst");

        // halt is sticky against any input
        drv(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1);
        exp_chk("halt_ev", mk(S_RUN, NONE, 3'b000, 1'b0));
        drv(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
        exp_chk("halt1", mk(S_HLT, NONE, 3'b000, 1'b1));
        drv(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
        exp_chk("halt2", mk(S_HLT, NONE, 3'b000, 1'b1));
        idle();
        exp_chk("halt3", mk(S_HLT, NONE, 3'b000, 1'b1));
        cnt_chk("cnt_halt");
        rst = 1'b1;
        exp_chk("halt_rst", mk(S_RUN, ALL, 3'b000, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
